// File: rtl/fu_alu_pipe_pkg.sv
// Shared types for the pipelined ALU functional unit: issue/complete packets,
// operand-select and ALU-function encodings, and RV32 immediate decoders.
package fu_alu_pipe_pkg;

  localparam int XLEN  = 32;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'h0,
    OPA_IS_NPC  = 2'h1,
    OPA_IS_PC   = 2'h2,
    OPA_IS_ZERO = 2'h3
  } ALU_OPA_SELECT;

  typedef enum logic [2:0] {
    OPB_IS_RS2   = 3'h0,
    OPB_IS_I_IMM = 3'h1,
    OPB_IS_S_IMM = 3'h2,
    OPB_IS_B_IMM = 3'h3,
    OPB_IS_U_IMM = 3'h4,
    OPB_IS_J_IMM = 3'h5
  } ALU_OPB_SELECT;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN-1:0]  NPC;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic [31:0]      inst;
    ALU_OPA_SELECT    opa_select;
    ALU_OPB_SELECT    opb_select;
    ALU_FUNC          alu_func;
    logic             rd_mem;
    logic             wr_mem;
    logic             cond_branch;
    logic             uncond_branch;
    logic             halt;
    logic [PR_W-1:0]  pr_idx;
    logic [4:0]       ar_idx;
    logic [ROB_W-1:0] rob_idx;
    logic             valid;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  dest_value;
    logic [XLEN-1:0]  target_pc;
    logic             take_branch;
    logic             rd_mem;
    logic             wr_mem;
    logic             halt;
    logic [PR_W-1:0]  pr_idx;
    logic [4:0]       ar_idx;
    logic [ROB_W-1:0] rob_idx;
    logic             valid;
  } FU_COMPLETE_PACKET;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
    return {{21{i[31]}}, i[30:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
    return {{21{i[31]}}, i[30:25], i[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'h000};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fu_alu_compute.sv
// Combinational stage-0 datapath: operand muxes, ALU and branch condition,
// folded into a FU_COMPLETE_PACKET ready to enter the first pipeline register.
module alu
  import fu_alu_pipe_pkg::*;
(
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  input  ALU_FUNC         func_i,
  output logic [XLEN-1:0] result_o
);
  always_comb begin
    result_o = '0;
    case (func_i)
      ALU_ADD:  result_o = opa_i + opb_i;
      ALU_SUB:  result_o = opa_i - opb_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(opa_i) < $signed(opb_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, opa_i < opb_i};
      ALU_AND:  result_o = opa_i & opb_i;
      ALU_OR:   result_o = opa_i | opb_i;
      ALU_XOR:  result_o = opa_i ^ opb_i;
      ALU_SLL:  result_o = opa_i << opb_i[4:0];
      ALU_SRL:  result_o = opa_i >> opb_i[4:0];
      ALU_SRA:  result_o = $signed(opa_i) >>> opb_i[4:0];
      default:  result_o = '0;
    endcase
  end
endmodule

module brcond
  import fu_alu_pipe_pkg::*;
(
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      func_i,
  output logic            cond_o
);
  always_comb begin
    cond_o = 1'b0;
    case (func_i)
      3'b000:  cond_o = (rs1_i == rs2_i);
      3'b001:  cond_o = (rs1_i != rs2_i);
      3'b100:  cond_o = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  cond_o = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  cond_o = (rs1_i <  rs2_i);
      3'b111:  cond_o = (rs1_i >= rs2_i);
      default: cond_o = 1'b0;
    endcase
  end
endmodule

module fu_alu_compute
  import fu_alu_pipe_pkg::*;
(
  input  ISSUE_FU_PACKET    issue_i,
  output FU_COMPLETE_PACKET pkt_o
);
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_result;
  logic            cond;

  always_comb begin
    opa = 32'hdeadfbac;
    case (issue_i.opa_select)
      OPA_IS_RS1:  opa = issue_i.rs1_value;
      OPA_IS_NPC:  opa = issue_i.NPC;
      OPA_IS_PC:   opa = issue_i.PC;
      OPA_IS_ZERO: opa = '0;
      default:     opa = 32'hdeadfbac;
    endcase
  end

  // Encodings 6 and 7 of the B select are unassigned and fall to the marker value.
  always_comb begin
    opb = 32'hfacefeed;
    case (issue_i.opb_select)
      OPB_IS_RS2:   opb = issue_i.rs2_value;
      OPB_IS_I_IMM: opb = imm_i(issue_i.inst);
      OPB_IS_S_IMM: opb = imm_s(issue_i.inst);
      OPB_IS_B_IMM: opb = imm_b(issue_i.inst);
      OPB_IS_U_IMM: opb = imm_u(issue_i.inst);
      OPB_IS_J_IMM: opb = imm_j(issue_i.inst);
      default:      opb = 32'hfacefeed;
    endcase
  end

  alu u_alu (
    .opa_i    (opa),
    .opb_i    (opb),
    .func_i   (issue_i.alu_func),
    .result_o (alu_result)
  );

  brcond u_brcond (
    .rs1_i  (issue_i.rs1_value),
    .rs2_i  (issue_i.rs2_value),
    .func_i (issue_i.inst[14:12]),
    .cond_o (cond)
  );

  always_comb begin
    pkt_o             = '0;
    pkt_o.opa         = opa;
    pkt_o.opb         = opb;
    pkt_o.dest_value  = alu_result;
    pkt_o.take_branch = issue_i.uncond_branch | (issue_i.cond_branch & cond);
    pkt_o.target_pc   = (issue_i.uncond_branch | issue_i.cond_branch) ? alu_result : '0;
    pkt_o.rd_mem      = issue_i.rd_mem;
    pkt_o.wr_mem      = issue_i.wr_mem;
    pkt_o.halt        = issue_i.halt;
    pkt_o.pr_idx      = issue_i.pr_idx;
    pkt_o.ar_idx      = issue_i.ar_idx;
    pkt_o.rob_idx     = issue_i.rob_idx;
    pkt_o.valid       = issue_i.valid;
  end
endmodule

// File: rtl/fu_alu_pipe.sv
// Pipelined ALU functional unit: stage-0 compute followed by NUM_STAGES elastic
// registers with complete-stage back-pressure, squash and an occupancy count.
module fu_alu_pipe
  import fu_alu_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  ISSUE_FU_PACKET    fu_issue_in,
  input  logic              complete_stall,
  input  logic              squash,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_packet_out,
  output logic [CNT_W-1:0]  in_flight
);
  FU_COMPLETE_PACKET issue_pkt;

  logic [NUM_STAGES:0]   adv;
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] in_valid;
  FU_COMPLETE_PACKET     pkt_q  [NUM_STAGES];
  FU_COMPLETE_PACKET     pkt_d  [NUM_STAGES];
  FU_COMPLETE_PACKET     in_pkt [NUM_STAGES];

  logic [CNT_W-1:0] in_flight_q;
  logic [CNT_W-1:0] in_flight_d;
  logic             accept;
  logic             consume;

  fu_alu_compute u_compute (
    .issue_i (fu_issue_in),
    .pkt_o   (issue_pkt)
  );

  // A stage may be overwritten when it is empty or its occupant moves on.
  always_comb begin
    adv             = '0;
    adv[NUM_STAGES] = ~complete_stall;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign in_valid[gi] = fu_issue_in.valid;
        assign in_pkt[gi]   = issue_pkt;
      end else begin : g_body
        assign in_valid[gi] = valid_q[gi-1];
        assign in_pkt[gi]   = pkt_q[gi-1];
      end
      assign valid_d[gi] = squash ? 1'b0 : (adv[gi] ? in_valid[gi] : valid_q[gi]);
      assign pkt_d[gi]   = (adv[gi] & in_valid[gi]) ? in_pkt[gi] : pkt_q[gi];
    end
  endgenerate

  assign accept      = fu_issue_in.valid & adv[0];
  assign consume     = valid_q[NUM_STAGES-1] & ~complete_stall;
  assign in_flight_d = squash ? '0 : (in_flight_q + CNT_W'(accept) - CNT_W'(consume));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      in_flight_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        pkt_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      in_flight_q <= in_flight_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        pkt_q[i] <= pkt_d[i];
      end
    end
  end

  assign fu_ready         = adv[0];
  assign want_to_complete = valid_q[NUM_STAGES-1];
  assign in_flight        = in_flight_q;

  always_comb begin
    fu_packet_out = '0;
    if (valid_q[NUM_STAGES-1]) begin
      fu_packet_out       = pkt_q[NUM_STAGES-1];
      fu_packet_out.valid = 1'b1;
    end
  end
endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
Parametrised, pipelined successor to the single-cycle ALU functional unit. It accepts one ISSUE_FU_PACKET per cycle. It computes the operand-mux, ALU and branch-condition results in the first stage, then carries the FU_COMPLETE_PACKET through NUM_STAGES registered stages. Those stages are elastic and honour complete-stage back-pressure (complete_stall) and a global squash. The unit sits between the issue stage and the complete stage. It replaces the always-ready combinational ALU FU, with a real fu_ready handshake and an in-flight occupancy count.

Parameters:
NUM_STAGES, 2, number of registered pipeline stages between issue and complete; legal range 1..4.
CNT_W, $clog2(NUM_STAGES+1), width of the occupancy counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
fu_issue_in  input  ISSUE_FU_PACKET  issued instruction; valid field qualifies it.
complete_stall  input  1  complete stage cannot accept this cycle.
squash  input  1  mispredict flush; kills everything in flight.
fu_ready  output  1  unit accepts fu_issue_in this cycle.
want_to_complete  output  1  last stage holds a valid result.
fu_packet_out  output  FU_COMPLETE_PACKET  result packet from the last stage.
in_flight  output  CNT_W  number of valid stages.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset_n is low:
  - all stage valid bits and stage payloads are 0;
  - want_to_complete = 0, fu_packet_out = 0, in_flight = 0, fu_ready = 1.
- Stage-0 compute (combinational on fu_issue_in):
  - opa mux: RS1 / NPC / PC / ZERO; default 32'hdeadfbac.
  - opb mux: RS2 / I / S / B / U / J sign-extended immediates; default 32'hfacefeed.
  - ALU on alu_func; brcond on rs1/rs2 with inst.b.funct3.
  - take_branch = uncond_branch | (cond_branch & cond).
  - target_pc = alu_result for any branch, else 0. dest_value = alu_result.
  - opa/opb are exported. rd_mem, wr_mem, halt, pr_idx, ar_idx and rob_idx pass through unchanged.
- Pipeline with stages s[0..NUM_STAGES-1]:
  - adv[NUM_STAGES] = !complete_stall; adv[i] = !valid[i] | adv[i+1].
  - fu_ready = adv[0]; this is a combinational path from complete_stall, by design.
- Accept: s[0] loads when fu_issue_in.valid & fu_ready.
  - If fu_ready = 0, the input is ignored; the issue stage must hold it.
- Transfer:
  - A stage with adv[i+1] = 1 passes its content forward.
  - A stage with adv[i+1] = 0 holds its payload bit-stable.
  - A stage that passes its content and receives nothing clears its valid bit.
- Output: want_to_complete = valid[NUM_STAGES-1]; fu_packet_out = s[NUM_STAGES-1] payload, with valid set.
  - The packet is consumed on any cycle with want_to_complete & !complete_stall.
  - Order is strictly FIFO.
- Latency: an instruction accepted in cycle t is presented in cycle t+NUM_STAGES when there are no stalls.
  - Throughput is 1 per cycle.
- Squash has priority over accept, transfer and stall:
  - all valid bits are 0 next cycle; an input presented in the squash cycle is dropped;
  - want_to_complete falls the cycle after squash;
  - fu_ready stays defined by the stall equations during the squash cycle.
- in_flight: registered count of valid bits. It is updated every cycle as
  in_flight + accept − consume, and becomes 0 after squash or reset.
  - Never exceeds NUM_STAGES.
- Full pipeline with complete_stall = 1: fu_ready = 0, and the output is held unchanged across all stall cycles.
- Full pipeline with complete_stall = 0: accept and consume happen in the same cycle (pass-through); in_flight is unchanged.
- Mid-operation reset: all in-flight work is discarded immediately and asynchronously; nothing reaches the output after reset release.

Decomposition:
- Shared package: ISSUE_FU_PACKET, FU_COMPLETE_PACKET, ALU_OPA_SELECT/ALU_OPB_SELECT enums, ALU_FUNC, the RV32 immediate macros, and XLEN.
- No new typedefs are needed.
- Natural sub-module: fu_alu_compute, the combinational stage-0 datapath. It instantiates the existing alu and brcond and produces a FU_COMPLETE_PACKET.
- fu_alu_pipe holds only the elastic registers, handshake and counter.

Test Plan:
1. ADD: rs1 = 5, rs2 = 7, OPA_IS_RS1 / OPB_IS_RS2, accepted in cycle t.
   -> dest_value 12 with want_to_complete in cycle t+2 (NUM_STAGES = 2); in_flight goes 1, 1, 0.
2. BEQ: rs1 = rs2 = 3, PC = 0x100, B-imm 0x20.
   -> take_branch 1, target_pc 0x120. The same with rs2 = 4 gives take_branch 0 and target_pc 0x120.
3. Issue 3 back-to-back ADDs (results 1, 2, 3) with complete_stall held high from the cycle the first reaches the output, for 4 cycles.
   -> fu_ready 0 once 2 are in flight; the output is held at 1; after release, 1, 2, 3 drain on consecutive cycles.
4. Two instructions in flight, then assert squash with a valid input in the same cycle.
   -> next cycle valid bits are 0, in_flight 0, want_to_complete 0; nothing emerges later.
5. Pipeline full with complete_stall = 0, issuing every cycle for 6 cycles.
   -> one result per cycle in order; fu_ready stays 1; in_flight stays 2.
6. Drop reset_n asynchronously between clock edges with 2 in flight.
   -> outputs are 0 immediately; after release, fu_ready is 1 and no stale result appears.
